// File: rtl/regfile_ctrl_if.sv
// Instruction and debug bus of regfile_ctrl.
// master drives instructions and debug requests; slave is the controller.
interface regfile_ctrl_if #(
  parameter int DW     = 8,
  parameter int NREG   = 4,
  parameter int MDEPTH = 16
);
  localparam int RW = $clog2(NREG);
  localparam int AW = $clog2(MDEPTH);

  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    op;
  logic [RW-1:0] rd;
  logic [RW-1:0] rs;
  logic [AW-1:0] addr;
  logic [3:0]    imm;
  logic          done;
  logic          err;
  logic          flag_cy;
  logic          flag_z;
  logic          dbg_rd_en;
  logic          dbg_wr_en;
  logic [RW-1:0] dbg_sel;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_ack;

  modport master (
    output instr_valid, op, rd, rs, addr, imm,
    output dbg_rd_en, dbg_wr_en, dbg_sel, dbg_wdata,
    input  instr_ready, done, err, flag_cy, flag_z, dbg_rdata, dbg_ack
  );

  modport slave (
    input  instr_valid, op, rd, rs, addr, imm,
    input  dbg_rd_en, dbg_wr_en, dbg_sel, dbg_wdata,
    output instr_ready, done, err, flag_cy, flag_z, dbg_rdata, dbg_ack
  );
endinterface

// File: rtl/regfile_ctrl.sv
// Small register-file controller: executes one instruction at a time against
// a register file and a data memory, with a debug port that gets the register
// file only when no instruction is being accepted.
module regfile_ctrl #(
  parameter int DW     = 8,
  parameter int NREG   = 4,
  parameter int MDEPTH = 16
) (
  input logic         clk,
  input logic         rst,
  regfile_ctrl_if.slave bus
);
  localparam int RW = $clog2(NREG);
  localparam int AW = $clog2(MDEPTH);

  localparam logic [3:0] OP_LD  = 4'b0000;
  localparam logic [3:0] OP_ST  = 4'b0001;
  localparam logic [3:0] OP_MI  = 4'b0010;
  localparam logic [3:0] OP_MR  = 4'b0011;
  localparam logic [3:0] OP_NOP = 4'b0100;
  localparam logic [3:0] OP_CM  = 4'b0111;
  localparam logic [3:0] OP_CMI = 4'b1111;

  typedef enum logic [1:0] {IDLE, MEMRD, RETIRE} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] mem  [MDEPTH];

  // instruction fields held past the handshake (only what later cycles need)
  logic [3:0]    op_p1;
  logic [AW-1:0] addr_p1;

  logic          ready_c;
  logic          done_c;
  logic          err_c;
  logic          hs;
  logic          dbg_go;
  logic [DW-1:0] cmp_b;
  logic          flag_cy_q;
  logic          flag_z_q;
  logic [DW-1:0] dbg_rdata_q;
  logic          dbg_ack_q;

  function automatic logic signed [DW-1:0] sext_imm(input logic [3:0] v);
    return {{(DW-4){v[3]}}, v};
  endfunction

  function automatic logic legal_op(input logic [3:0] o);
    case (o)
      OP_LD, OP_ST, OP_MI, OP_MR, OP_NOP, OP_CM, OP_CMI: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state and retire-cycle outputs
  always_comb begin
    state_nx = state;
    ready_c  = 1'b0;
    done_c   = 1'b0;
    err_c    = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.instr_valid && !rst) state_nx = (bus.op == OP_LD) ? MEMRD : RETIRE;
      end
      MEMRD:  state_nx = RETIRE;
      RETIRE: begin
        done_c   = 1'b1;
        err_c    = !legal_op(op_p1);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign hs     = ready_c && !rst && bus.instr_valid;
  // an instruction in the same IDLE cycle always wins over the debug port
  assign dbg_go = ready_c && !rst && !bus.instr_valid && (bus.dbg_rd_en || bus.dbg_wr_en);
  assign cmp_b  = (bus.op == OP_CM) ? regs[bus.rs] : sext_imm(bus.imm);

  // latch the fields needed after the handshake edge
  always_ff @(posedge clk) begin
    if (hs) begin
      op_p1   <= bus.op;
      addr_p1 <= bus.addr;
    end
  end

  // register file, flags and debug port; single-cycle ops commit at the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      flag_cy_q   <= 1'b0;
      flag_z_q    <= 1'b0;
      dbg_rdata_q <= '0;
      dbg_ack_q   <= 1'b0;
    end else begin
      dbg_ack_q <= dbg_go;
      // read samples the old value, so a simultaneous write still returns it
      if (dbg_go && bus.dbg_rd_en) dbg_rdata_q <= regs[bus.dbg_sel];
      if (dbg_go && bus.dbg_wr_en) regs[bus.dbg_sel] <= bus.dbg_wdata;
      if (hs) begin
        case (bus.op)
          OP_MR: regs[bus.rd] <= regs[bus.rs];
          OP_MI: regs[bus.rd] <= sext_imm(bus.imm);
          OP_CM, OP_CMI: begin
            flag_z_q  <= (regs[bus.rd] == cmp_b);
            flag_cy_q <= (regs[bus.rd] <  cmp_b);
          end
          default: ;
        endcase
      end
      // load result lands as the block enters RETIRE
      if (state == MEMRD) regs[0] <= mem[addr_p1];
    end
  end

  // data memory write port, deliberately not reset
  always_ff @(posedge clk) begin
    if (hs && bus.op == OP_ST) mem[bus.addr] <= regs[0];
  end

  assign bus.instr_ready = ready_c && !rst;
  assign bus.done        = done_c;
  assign bus.err         = err_c;
  assign bus.flag_cy     = flag_cy_q;
  assign bus.flag_z      = flag_z_q;
  assign bus.dbg_rdata   = dbg_rdata_q;
  assign bus.dbg_ack     = dbg_ack_q;
endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a transaction-level reference model.
module tb_regfile_ctrl;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errs    = 0;
  bit   armed   = 1'b0;

  regfile_ctrl_if #(.DW(8), .NREG(4), .MDEPTH(16)) bus ();
  regfile_ctrl #(.DW(8), .NREG(4), .MDEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // reference model state
  logic [7:0] m_regs [4];
  logic [7:0] m_mem  [16];
  logic       m_cy, m_z, m_done, m_err, m_ack;
  logic [7:0] m_rdata;
  logic [3:0] ld_addr;
  int         left;    // edges remaining until the block is idle again

  function automatic logic [7:0] sx(input logic [3:0] v);
    logic signed [3:0] s;
    int w;
    s = v;
    w = s;
    return w[7:0];
  endfunction

  task automatic model_step();
    int old;
    logic [7:0] a, b;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_cy = 0; m_z = 0; m_done = 0; m_err = 0; m_ack = 0; m_rdata = 8'h00;
      left = 0; armed = 1'b1;
    end else begin
      old = left;
      if (left > 0) left--;
      m_done = 0; m_err = 0; m_ack = 0;
      if (old == 2) begin
        m_regs[0] = m_mem[ld_addr];
        m_done = 1;
      end
      if (old == 0 && bus.instr_valid) begin
        left = 1; m_done = 1;
        case (bus.op)
          4'b0000: begin ld_addr = bus.addr; left = 2; m_done = 0; end
          4'b0001: m_mem[bus.addr] = m_regs[0];
          4'b0011: m_regs[bus.rd] = m_regs[bus.rs];
          4'b0010: m_regs[bus.rd] = sx(bus.imm);
          4'b0111, 4'b1111: begin
            a = m_regs[bus.rd];
            b = (bus.op == 4'b0111) ? m_regs[bus.rs] : sx(bus.imm);
            m_z  = (a == b);
            m_cy = (a < b);
          end
          4'b0100: ;
          default: m_err = 1;
        endcase
      end else if (old == 0 && (bus.dbg_rd_en || bus.dbg_wr_en)) begin
        m_ack = 1;
        if (bus.dbg_rd_en) m_rdata = m_regs[bus.dbg_sel];
        if (bus.dbg_wr_en) m_regs[bus.dbg_sel] = bus.dbg_wdata;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (armed) begin
      cmp("ready",   bus.instr_ready, (left == 0) && !rst);
      cmp("done",    bus.done,    m_done);
      cmp("err",     bus.err,     m_err);
      cmp("flag_cy", bus.flag_cy, m_cy);
      cmp("flag_z",  bus.flag_z,  m_z);
      cmp("dbg_ack", bus.dbg_ack, m_ack);
      cmp("dbg_rdata", bus.dbg_rdata, m_rdata);
    end
  end

  task automatic issue(input logic [3:0] o, input logic [1:0] d, input logic [1:0] s,
                       input logic [3:0] a, input logic [3:0] i);
    int n;
    n = 0;
    @(negedge clk);
    bus.op = o; bus.rd = d; bus.rs = s; bus.addr = a; bus.imm = i;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) cmp("handshake_timeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  task automatic dbg(input logic r, input logic w, input logic [1:0] sel,
                     input logic [7:0] wd, output int n);
    n = 0;
    @(negedge clk);
    bus.dbg_rd_en = r; bus.dbg_wr_en = w; bus.dbg_sel = sel; bus.dbg_wdata = wd;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.dbg_ack && n < 20);
    if (n >= 20) cmp("dbg_timeout", 32'(n), 32'd0);
    bus.dbg_rd_en = 1'b0; bus.dbg_wr_en = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.instr_valid = 0; bus.op = 0; bus.rd = 0; bus.rs = 0; bus.addr = 0; bus.imm = 0;
    bus.dbg_rd_en = 0; bus.dbg_wr_en = 0; bus.dbg_sel = 0; bus.dbg_wdata = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    cmp("rst_ready", bus.instr_ready, 1'b0);
    cmp("rst_flags", {bus.flag_cy, bus.flag_z}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    cmp("post_rst_ready", bus.instr_ready, 1'b1);

    // MI sign extension and debug read latency
    issue(4'b0010, 2'd2, 2'd0, 4'd0, 4'b1110);
    cmp("mi_done_n1", bus.done, 1'b1);
    dbg(1'b1, 1'b0, 2'd2, 8'h00, n);
    cmp("r2_fe", bus.dbg_rdata, 8'hFE);
    cmp("dbg_latency", 32'(n), 32'd1);

    // store / clear / load round trip
    dbg(1'b0, 1'b1, 2'd0, 8'h5A, n);
    issue(4'b0001, 2'd0, 2'd0, 4'd7, 4'd0);
    issue(4'b0010, 2'd0, 2'd0, 4'd0, 4'd0);
    dbg(1'b1, 1'b0, 2'd0, 8'h00, n);
    cmp("r0_cleared", bus.dbg_rdata, 8'h00);
    issue(4'b0000, 2'd0, 2'd0, 4'd7, 4'd0);
    cmp("ld_done_n1", bus.done, 1'b0);
    @(negedge clk);
    cmp("ld_done_n2", bus.done, 1'b1);
    dbg(1'b1, 1'b0, 2'd0, 8'h00, n);
    cmp("r0_loaded", bus.dbg_rdata, 8'h5A);

    // compares and flag hold
    dbg(1'b0, 1'b1, 2'd1, 8'h03, n);
    dbg(1'b0, 1'b1, 2'd2, 8'h05, n);
    issue(4'b0111, 2'd1, 2'd2, 4'd0, 4'd0);
    cmp("cm_lt_flags", {bus.flag_cy, bus.flag_z}, 2'b10);
    issue(4'b0111, 2'd2, 2'd2, 4'd0, 4'd0);
    cmp("cm_eq_flags", {bus.flag_cy, bus.flag_z}, 2'b01);
    issue(4'b0011, 2'd3, 2'd1, 4'd0, 4'd0);
    cmp("mr_flags_hold", {bus.flag_cy, bus.flag_z}, 2'b01);
    issue(4'b1111, 2'd1, 2'd0, 4'd0, 4'hF);
    cmp("cmi_flags", {bus.flag_cy, bus.flag_z}, 2'b10);

    // illegal opcode
    issue(4'b1010, 2'd3, 2'd1, 4'd0, 4'd5);
    cmp("illegal_done_err", {bus.done, bus.err}, 2'b11);
    cmp("illegal_flags", {bus.flag_cy, bus.flag_z}, 2'b10);
    dbg(1'b1, 1'b0, 2'd3, 8'h00, n);
    cmp("r3_after_illegal", bus.dbg_rdata, 8'h03);

    // simultaneous debug read and write: old value returned, write lands
    dbg(1'b1, 1'b1, 2'd1, 8'hAA, n);
    cmp("rw_old_value", bus.dbg_rdata, 8'h03);
    dbg(1'b1, 1'b0, 2'd1, 8'h00, n);
    cmp("rw_new_value", bus.dbg_rdata, 8'hAA);

    // back-to-back single-cycle instructions
    issue(4'b0100, 2'd0, 2'd0, 4'd0, 4'd0);
    issue(4'b0100, 2'd0, 2'd0, 4'd0, 4'd0);

    // instruction beats a concurrent debug write
    @(negedge clk);
    bus.op = 4'b0010; bus.rd = 2'd1; bus.imm = 4'h7; bus.instr_valid = 1'b1;
    bus.dbg_wr_en = 1'b1; bus.dbg_sel = 2'd2; bus.dbg_wdata = 8'h33;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    cmp("prio_ack_retire", bus.dbg_ack, 1'b0);
    cmp("prio_done", bus.done, 1'b1);
    @(negedge clk);
    cmp("prio_ack_idle", bus.dbg_ack, 1'b0);
    @(negedge clk);
    cmp("prio_ack_late", bus.dbg_ack, 1'b1);
    bus.dbg_wr_en = 1'b0;
    dbg(1'b1, 1'b0, 2'd1, 8'h00, n);
    cmp("prio_r1", bus.dbg_rdata, 8'h07);
    dbg(1'b1, 1'b0, 2'd2, 8'h00, n);
    cmp("prio_r2", bus.dbg_rdata, 8'h33);

    // reset during the MEMRD cycle of a load
    issue(4'b0000, 2'd0, 2'd0, 4'd7, 4'd0);
    rst = 1'b1;
    @(negedge clk);
    cmp("abort_no_done", bus.done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    cmp("abort_ready", bus.instr_ready, 1'b1);
    cmp("abort_done", bus.done, 1'b0);
    dbg(1'b1, 1'b0, 2'd0, 8'h00, n);
    cmp("abort_r0", bus.dbg_rdata, 8'h00);

    // final sweep of the register file
    for (int i = 0; i < 4; i++) dbg(1'b1, 1'b0, 2'(i), 8'h00, n);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
